// File: rtl/rv32_types.sv
// Shared RV32 types for the instruction-memory responder.
// Holds the responder FSM state encoding and the canonical NOP word.
package rv32_types;

  typedef logic [31:0] rv32_word;
  typedef logic [31:0] rv_instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } imem_state_t;

  localparam rv_instr_t RV32_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/rv32_imem_array.sv
// DEPTH x 32 instruction storage, one sync write port, one sync read port.
// Contents are never reset; a same-address write is forwarded to the read.
module rv32_imem_array
  import rv32_types::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  rv_instr_t     i_wdata,
  input  logic [AW-1:0] i_raddr,
  output rv_instr_t     o_rdata
);

  rv_instr_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_we && (i_waddr == i_raddr)) begin
      o_rdata <= i_wdata;
    end else begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/rv32_imem_responder.sv
// Wait-state instruction memory responder for an RV32 fetch port.
// Define RV32_IMEM_WAIT_STATES_EN to honour WAIT_STATES; otherwise WAIT is one cycle.
module rv32_imem_responder
  import rv32_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter rv32_word    BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  rv32_word                       instr_addr,
  output rv_instr_t                      instr_bus,
  output logic                           instr_ready,
  output logic                           access_err,
  input  logic                           load_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  imem_state_t state;
  rv32_word    lat_addr;

  rv32_word      w_lat_off;
  rv32_word      w_rd_off;
  logic [AW-1:0] w_lat_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_lat_err;
  logic          w_restart;
  logic          w_load_hit;
  logic          w_wait_done;
  rv_instr_t     w_rd_data;
  logic          w_unused;

  assign w_lat_off = lat_addr - BASE_ADDR;
  assign w_lat_idx = w_lat_off[AW+1:2];
  assign w_lat_err = (lat_addr[1:0] != 2'b00)
                   || (w_lat_off[31:AW+2] != '0);

  // Read index follows the live address so the word is fetched at latch time.
  assign w_rd_off = instr_addr - BASE_ADDR;
  assign w_rd_idx = w_rd_off[AW+1:2];

  assign w_restart  = (instr_addr != lat_addr) || (state == IDLE);
  assign w_load_hit = load_we && (state != IDLE)
                    && !w_lat_err && (load_addr == w_lat_idx);

  assign instr_ready = (state == READY) && (instr_addr == lat_addr);

`ifdef RV32_IMEM_WAIT_STATES_EN
  logic [3:0] cnt;
  assign w_wait_done = (cnt == 4'd0);
  assign w_unused    = ^{w_lat_off[1:0], w_rd_off[31:AW+2],
                         w_rd_off[1:0]};
`else
  assign w_wait_done = 1'b1;
  assign w_unused    = ^{w_lat_off[1:0], w_rd_off[31:AW+2],
                         w_rd_off[1:0], (WAIT_STATES != 0)};
`endif

  rv32_imem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (load_we),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_addr   <= '0;
      instr_bus  <= RV32_NOP_INSTR;
      access_err <= 1'b0;
`ifdef RV32_IMEM_WAIT_STATES_EN
      cnt        <= 4'd0;
`endif
    end else if (w_restart) begin
      lat_addr <= instr_addr;
      state    <= WAIT;
`ifdef RV32_IMEM_WAIT_STATES_EN
      cnt      <= 4'(WAIT_STATES);
`endif
    end else if (w_load_hit) begin
      state <= WAIT;
`ifdef RV32_IMEM_WAIT_STATES_EN
      cnt   <= 4'(WAIT_STATES);
`endif
    end else begin
      unique case (state)
        WAIT: begin
          if (w_wait_done) begin
            state      <= READY;
            access_err <= w_lat_err;
            instr_bus  <= w_lat_err ? RV32_NOP_INSTR : w_rd_data;
          end
`ifdef RV32_IMEM_WAIT_STATES_EN
          if (!w_wait_done) begin
            cnt <= cnt - 4'd1;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_imem_responder.sv
// Scoreboard bench for rv32_imem_responder: driver queues expectations,
// a negedge monitor checks ready timing and the returned word.
module tb_rv32_imem_responder;
  import rv32_types::*;

  localparam int unsigned DEPTH = 16;
`ifdef RV32_IMEM_WAIT_STATES_EN
  localparam int unsigned WS  = 2;
  localparam int          EFF = 2;
`else
  localparam int unsigned WS  = 5;
  localparam int          EFF = 0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] bus;
    logic        err;
    int          lo_cyc;
    int          rdy_cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  rv32_word    instr_addr;
  rv_instr_t   instr_bus;
  logic        instr_ready;
  logic        access_err;
  logic        load_we;
  logic [3:0]  load_addr;
  logic [31:0] load_data;

  exp_t q[$];
  exp_t m_e;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  rv32_imem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_STATES (WS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_addr  (instr_addr),
    .instr_bus   (instr_bus),
    .instr_ready (instr_ready),
    .access_err  (access_err),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      m_e = q[0];
      if (cyc == m_e.rdy_cyc) begin
        chk("ready_rise", 32'(instr_ready), 32'd1);
        chk("instr_bus", instr_bus, m_e.bus);
        chk("access_err", 32'(access_err), 32'(m_e.err));
        void'(q.pop_front());
      end else if (cyc >= m_e.lo_cyc) begin
        chk("ready_low", 32'(instr_ready), 32'd0);
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 once the expectation is consumed.
  task automatic drive(input logic [31:0] a, input logic we,
                       input logic [3:0] li, input logic [31:0] ld,
                       input int lo_off, input logic [31:0] eb,
                       input logic ee);
    int n;
    instr_addr = a;
    load_we    = we;
    load_addr  = li;
    load_data  = ld;
    q.push_back('{eb, ee, cyc + lo_off, cyc + EFF + 2});
    @(posedge clk); #2;
    load_we = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    if (q.size() != 0) begin
      chk("timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic preload(input logic [3:0] li, input logic [31:0] ld);
    load_we   = 1'b1;
    load_addr = li;
    load_data = ld;
    @(posedge clk); #2;
    load_we = 1'b0;
  endtask

  initial begin
    cyc        = 0;
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    instr_addr = 32'hFFFF_FFF0;
    load_we    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_bus", instr_bus, NOP);
    chk("rst_err", 32'(access_err), 32'd0);
    reset = 1'b0;

    preload(4'd0, 32'h0050_0093);
    preload(4'd1, 32'h0010_0113);
    preload(4'd2, 32'h0020_8193);
    preload(4'd3, 32'h4000_0237);

    drive(32'h0, 1'b0, 4'd0, 32'h0, 0, 32'h0050_0093, 1'b0);
    drive(32'h4, 1'b0, 4'd0, 32'h0, 0, 32'h0010_0113, 1'b0);
    drive(32'h2, 1'b0, 4'd0, 32'h0, 0, NOP, 1'b1);
    drive(32'h40, 1'b0, 4'd0, 32'h0, 0, NOP, 1'b1);
    drive(32'hC, 1'b0, 4'd0, 32'h0, 0, 32'h4000_0237, 1'b0);
    drive(32'h8, 1'b0, 4'd0, 32'h0, 0, 32'h0020_8193, 1'b0);
    // Load to the latched index while READY restarts the access.
    drive(32'h8, 1'b1, 4'd2, 32'hFFF0_0113, 1, 32'hFFF0_0113, 1'b0);
    // Load to another index must leave READY alone.
    preload(4'd5, 32'h0030_0293);
    chk("ready_kept", 32'(instr_ready), 32'd1);
    chk("bus_kept", instr_bus, 32'hFFF0_0113);
    drive(32'h14, 1'b0, 4'd0, 32'h0, 0, 32'h0030_0293, 1'b0);
    // Address change and load in the same cycle.
    drive(32'h10, 1'b1, 4'd4, 32'h0040_0313, 0, 32'h0040_0313, 1'b0);

    // Reset while waiting: outputs clear without a clock edge.
    drive(32'hC, 1'b0, 4'd0, 32'h0, 0, 32'h4000_0237, 1'b0);
    instr_addr = 32'h2;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(instr_ready), 32'd0);
    chk("mid_rst_bus", instr_bus, NOP);
    chk("mid_rst_err", 32'(access_err), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    drive(32'h4, 1'b0, 4'd0, 32'h0, 0, 32'h0010_0113, 1'b0);

    // Reset while READY with an error latched.
    drive(32'h2, 1'b0, 4'd0, 32'h0, 0, NOP, 1'b1);
    reset = 1'b1;
    #1;
    chk("rdy_rst_ready", 32'(instr_ready), 32'd0);
    chk("rdy_rst_err", 32'(access_err), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    drive(32'h0, 1'b0, 4'd0, 32'h0, 0, 32'h0050_0093, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32_imem_responder.md
RV32_IMEM_RESPONDER -- requirements
Module: rv32_imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, instruction storage depth in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 2, extra cycles per access (0..15).
REQ-004 SHALL use one clock, with asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 instr_addr  input  32 (rv32_word)  byte fetch address, driven continuously by core.
REQ-008 instr_bus  output  32 (rv_instr_t)  instruction word for latched address.
REQ-009 instr_ready  output  1  instr_bus valid for current instr_addr.
REQ-010 access_err  output  1  latched address misaligned or outside storage; qualified by instr_ready.
REQ-011 load_we  input  1  preload write strobe.
REQ-012 load_addr  input  $clog2(DEPTH_WORDS)  preload word index.
REQ-013 load_data  input  32  preload word.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, READY held in register state.
REQ-015 SHALL hold lat_addr; each edge, instr_addr != lat_addr or state==IDLE -> lat_addr<=instr_addr, cnt<=WAIT_STATES, state<=WAIT.
REQ-016 WAIT with cnt>0 SHALL decrement cnt; WAIT with cnt==0 SHALL register storage word into instr_bus and go READY.
REQ-017 READY SHALL persist while instr_addr == lat_addr; instr_bus unchanged.
REQ-018 instr_ready SHALL equal (state==READY) && (instr_addr==lat_addr), combinationally, so a changed address never sees stale ready.
REQ-019 Latency: address stable from edge N -> instr_ready high in cycle after edge N+WAIT_STATES+1.
REQ-020 Word index SHALL be (lat_addr-BASE_ADDR)>>2; misaligned (lat_addr[1:0]!=0) or index >= DEPTH_WORDS SHALL set access_err=1 and instr_bus=32'h0000_0013 (NOP) on entry to READY.
REQ-021 load_we SHALL write load_data at load_addr at edge; if load_addr equals the latched word index in WAIT or READY, access SHALL restart (state<=WAIT, cnt<=WAIT_STATES).
REQ-022 Address change and load_we same cycle: both take effect; restart per REQ-015.
REQ-023 Storage contents SHALL be undefined until loaded; not affected by reset.

Reset
REQ-024 Reset asserted SHALL immediately force state=IDLE, cnt=0, lat_addr=0, instr_bus=32'h0000_0013, access_err=0, instr_ready=0, aborting any access.
REQ-025 First access after reset release SHALL start at first edge with reset low.

Configuration
REQ-026 Macro RV32_IMEM_WAIT_STATES_EN defined: WAIT_STATES honoured per REQ-016/019.
REQ-027 Macro undefined: cnt removed, WAIT always lasts one cycle, latency fixed as WAIT_STATES=0; parameter ignored.

Structure
REQ-028 rv32_types SHALL gain imem_state_t (IDLE/WAIT/READY) and constant RV32_NOP_INSTR=32'h0000_0013.
REQ-029 Storage SHALL be sub-module rv32_imem_array: one synchronous write port, one synchronous read port, DEPTH_WORDS x 32.

Verification
REQ-030 Reset, load 0x00500093 at index 0, WAIT_STATES=2, instr_addr=0 -> instr_ready low 3 cycles, then high with instr_bus=0x00500093, access_err=0.
REQ-031 In READY at addr 0, instr_addr switches to 4 -> instr_ready drops same cycle, rises 3 cycles later with word 1.
REQ-032 instr_addr=0x2 -> READY with access_err=1, instr_bus=0x00000013; instr_addr=4*DEPTH_WORDS likewise.
REQ-033 In READY at addr 8, load_we to index 2 with 0xFFF00113 -> ready drops, returns after 3 cycles with 0xFFF00113.
REQ-034 Reset asserted mid-WAIT -> outputs at reset values without clock edge; after release access restarts.
REQ-035 Macro undefined build, WAIT_STATES=5 -> every access ready exactly one cycle after address stable.
